// File: rtl/tcm_pkg.sv
// Shared definitions for the two-port tightly-coupled memory: the fetch
// NOP word, the response record carried through the latency pipe and a
// helper that tells whether a read latency is supported.
package tcm_pkg;

    // Widest word the response record can carry; narrower words are zero-extended.
    localparam int unsigned TCM_MAX_DATA_W = 128;

    // Canonical RISC-V NOP (addi x0, x0, 0) returned for failed fetches.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic                      valid;
        logic                      err;
        logic [TCM_MAX_DATA_W-1:0] rdata;
    } tcm_resp_t;

    // Only one or two register stages between acceptance and response exist.
    function automatic bit tcm_rd_lat_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/tcm_resp_pipe.sv
// Response delay line for one memory port. The valid bit shifts through
// every stage each cycle, while err/rdata in a stage only change when a
// valid response enters it, so the outputs hold between pulses.
module tcm_resp_pipe
    import tcm_pkg::*;
#(
    parameter int unsigned               RD_LAT     = 1,
    parameter logic [TCM_MAX_DATA_W-1:0] RESET_DATA = '0
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  tcm_resp_t i_resp,
    output tcm_resp_t o_resp
);

    tcm_resp_t [RD_LAT-1:0] r_stage;

    // Shift responses one stage per cycle; a reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                r_stage[k] <= '{valid: 1'b0, err: 1'b0, rdata: RESET_DATA};
            end
        end else begin
            r_stage[0].valid <= i_resp.valid;
            if (i_resp.valid) begin
                r_stage[0].err   <= i_resp.err;
                r_stage[0].rdata <= i_resp.rdata;
            end
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                r_stage[k].valid <= r_stage[k-1].valid;
                if (r_stage[k-1].valid) begin
                    r_stage[k].err   <= r_stage[k-1].err;
                    r_stage[k].rdata <= r_stage[k-1].rdata;
                end
            end
        end
    end

    assign o_resp = r_stage[RD_LAT-1];

endmodule

// File: rtl/tcm_2p.sv
// Two-port tightly-coupled memory: a data port for loads/stores and an
// instruction port for fetch. Both ports are always granted, read the array
// at acceptance and answer after RD_LAT cycles. A store and a fetch hitting
// the same word in one cycle give the fetch the freshly written bytes.
module tcm_2p
    import tcm_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 16384,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       RD_LAT    = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_err_o,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_gnt_o,
    output logic                i_rvalid_o,
    output logic [DATA_W-1:0]   i_rdata_o,
    output logic                i_err_o
);

    localparam int unsigned     BYTES    = DATA_W / 8;
    localparam int unsigned     OFF_W    = $clog2(BYTES);
    localparam int unsigned     IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN     = (ADDR_W + 1)'(DEPTH * BYTES);
    localparam logic [ADDR_W:0] BASE_EXT = {1'b0, BASE_ADDR};

    if (!tcm_rd_lat_ok(RD_LAT) || (DATA_W % 8 != 0) || (DATA_W < 32) ||
        (DATA_W > TCM_MAX_DATA_W) || (DEPTH != (1 << IDX_W))) begin : g_badParams
        $error("tcm_2p: unsupported parameter combination");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W:0]   w_dOff;
    logic [ADDR_W:0]   w_iOff;
    logic              w_dInRange;
    logic              w_iInRange;
    logic [IDX_W-1:0]  w_dIdx;
    logic [IDX_W-1:0]  w_iIdx;
    logic              w_dWrite;
    logic [DATA_W-1:0] w_dWord;
    logic [DATA_W-1:0] w_iWord;
    logic [DATA_W-1:0] w_iMerged;
    tcm_resp_t         w_dRespIn;
    tcm_resp_t         w_iRespIn;
    tcm_resp_t         w_dResp;
    tcm_resp_t         w_iResp;
    logic              w_unusedOff;

    // Offsets are taken one bit wider than the address so that an address
    // below the base shows up as a huge value instead of wrapping into range.
    assign w_dOff     = {1'b0, d_addr_i} - BASE_EXT;
    assign w_iOff     = {1'b0, i_addr_i} - BASE_EXT;
    assign w_dInRange = (w_dOff < SPAN);
    assign w_iInRange = (w_iOff < SPAN);
    assign w_dIdx     = w_dOff[OFF_W +: IDX_W];
    assign w_iIdx     = w_iOff[OFF_W +: IDX_W];
    assign w_unusedOff = ^{w_dOff, w_iOff};

    assign d_gnt_o  = rst_n_i & d_req_i;
    assign i_gnt_o  = rst_n_i & i_req_i;
    assign w_dWrite = rst_n_i & d_req_i & d_we_i & w_dInRange;

    assign w_dWord = r_mem[w_dIdx];
    assign w_iWord = r_mem[w_iIdx];

    // Store enabled bytes at the accepting edge; the array itself has no reset.
    always_ff @(posedge clk_i) begin
        if (w_dWrite) begin
            for (int b = 0; b < BYTES; b++) begin
                if (d_be_i[b]) begin
                    r_mem[w_dIdx][8*b +: 8] <= d_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // A fetch to the word being stored this cycle sees the new bytes where enabled.
    always_comb begin
        w_iMerged = w_iWord;
        if (w_dWrite && (w_dIdx == w_iIdx)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (d_be_i[b]) begin
                    w_iMerged[8*b +: 8] = d_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Build the response each port would give for this cycle's request.
    always_comb begin
        w_dRespIn       = '0;
        w_dRespIn.valid = d_req_i;
        w_dRespIn.err   = ~w_dInRange;
        if (w_dInRange && !d_we_i) begin
            w_dRespIn.rdata = TCM_MAX_DATA_W'(w_dWord);
        end

        w_iRespIn       = '0;
        w_iRespIn.valid = i_req_i;
        w_iRespIn.err   = ~w_iInRange;
        if (w_iInRange) begin
            w_iRespIn.rdata = TCM_MAX_DATA_W'(w_iMerged);
        end else begin
            w_iRespIn.rdata = TCM_MAX_DATA_W'(NOP_INSN);
        end
    end

    tcm_resp_pipe #(
        .RD_LAT     (RD_LAT),
        .RESET_DATA ('0)
    ) u_dPipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_resp  (w_dRespIn),
        .o_resp  (w_dResp)
    );

    tcm_resp_pipe #(
        .RD_LAT     (RD_LAT),
        .RESET_DATA (TCM_MAX_DATA_W'(NOP_INSN))
    ) u_iPipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_resp  (w_iRespIn),
        .o_resp  (w_iResp)
    );

    assign d_rvalid_o = w_dResp.valid;
    assign d_err_o    = w_dResp.err;
    assign d_rdata_o  = w_dResp.rdata[DATA_W-1:0];
    assign i_rvalid_o = w_iResp.valid;
    assign i_err_o    = w_iResp.err;
    assign i_rdata_o  = w_iResp.rdata[DATA_W-1:0];

    if (DATA_W < TCM_MAX_DATA_W) begin : g_padSink
        logic w_unusedPad;
        assign w_unusedPad = ^{w_dResp.rdata[TCM_MAX_DATA_W-1:DATA_W],
                               w_iResp.rdata[TCM_MAX_DATA_W-1:DATA_W]};
    end

endmodule

// File: tb/tb_tcm_2p.sv
// Directed bench for tcm_2p. Two instances share one set of inputs: one
// with a single-cycle response and one with the extra output stage, so
// every write lands in both arrays and both can be checked for latency.
module tb_tcm_2p;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clock;
    logic        rstN;
    logic        dReq;
    logic        dWe;
    logic [3:0]  dBe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        iReq;
    logic [31:0] iAddr;

    logic        d1Gnt, d1Rvalid, d1Err, i1Gnt, i1Rvalid, i1Err;
    logic [31:0] d1Rdata, i1Rdata;
    logic        d2Gnt, d2Rvalid, d2Err, i2Gnt, i2Rvalid, i2Err;
    logic [31:0] d2Rdata, i2Rdata;

    int numCompared   = 0;
    int numMismatched = 0;

    tcm_2p #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE), .RD_LAT(1)
    ) u_dutLat1 (
        .clk_i(clock), .rst_n_i(rstN),
        .d_req_i(dReq), .d_we_i(dWe), .d_be_i(dBe), .d_addr_i(dAddr), .d_wdata_i(dWdata),
        .d_gnt_o(d1Gnt), .d_rvalid_o(d1Rvalid), .d_rdata_o(d1Rdata), .d_err_o(d1Err),
        .i_req_i(iReq), .i_addr_i(iAddr),
        .i_gnt_o(i1Gnt), .i_rvalid_o(i1Rvalid), .i_rdata_o(i1Rdata), .i_err_o(i1Err)
    );

    tcm_2p #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE), .RD_LAT(2)
    ) u_dutLat2 (
        .clk_i(clock), .rst_n_i(rstN),
        .d_req_i(dReq), .d_we_i(dWe), .d_be_i(dBe), .d_addr_i(dAddr), .d_wdata_i(dWdata),
        .d_gnt_o(d2Gnt), .d_rvalid_o(d2Rvalid), .d_rdata_o(d2Rdata), .d_err_o(d2Err),
        .i_req_i(iReq), .i_addr_i(iAddr),
        .i_gnt_o(i2Gnt), .i_rvalid_o(i2Rvalid), .i_rdata_o(i2Rdata), .i_err_o(i2Err)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests from a falling edge, check the grants, and
    // return at the next falling edge where a one-cycle response is visible.
    task automatic applyStimulus(input logic dReqV, input logic dWeV, input logic [3:0] dBeV,
                                 input logic [31:0] dAddrV, input logic [31:0] dWdataV,
                                 input logic iReqV, input logic [31:0] iAddrV);
        dReq   = dReqV;
        dWe    = dWeV;
        dBe    = dBeV;
        dAddr  = dAddrV;
        dWdata = dWdataV;
        iReq   = iReqV;
        iAddr  = iAddrV;
        #1;
        checkOutput("d_gnt", {31'b0, d1Gnt}, {31'b0, dReqV & rstN});
        checkOutput("i_gnt", {31'b0, i2Gnt}, {31'b0, iReqV & rstN});
        @(negedge clock);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Main directed sequence.
    initial begin
        rstN = 1'b0; dReq = 1'b1; dWe = 1'b0; dBe = 4'h0; dAddr = BASE;
        dWdata = 32'h0; iReq = 1'b1; iAddr = BASE;

        repeat (3) @(negedge clock);
        checkOutput("rst d_gnt",    {31'b0, d1Gnt},    32'h0);
        checkOutput("rst i_gnt",    {31'b0, i1Gnt},    32'h0);
        checkOutput("rst d_rvalid", {31'b0, d1Rvalid}, 32'h0);
        checkOutput("rst i_rvalid", {31'b0, i1Rvalid}, 32'h0);
        checkOutput("rst d2_rvalid",{31'b0, d2Rvalid}, 32'h0);
        checkOutput("rst i2_rvalid",{31'b0, i2Rvalid}, 32'h0);
        checkOutput("rst d_err",    {31'b0, d1Err},    32'h0);
        checkOutput("rst i_err",    {31'b0, i1Err},    32'h0);

        rstN = 1'b1; dReq = 1'b0; iReq = 1'b0;
        @(negedge clock);
        checkOutput("post-rst i_rdata",  i1Rdata, NOP);
        checkOutput("post-rst i2_rdata", i2Rdata, NOP);
        checkOutput("post-rst d_rdata",  d1Rdata, 32'h0);
        checkOutput("post-rst d_rvalid", {31'b0, d1Rvalid}, 32'h0);

        // Partial-byte write over a cleared word, then read it back.
        applyStimulus(1'b1, 1'b1, 4'hF, BASE + 32'd8, 32'h0, 1'b0, 32'h0);
        checkOutput("clear wr rvalid", {31'b0, d1Rvalid}, 32'h1);
        applyStimulus(1'b1, 1'b1, 4'b0101, BASE + 32'd8, 32'hDEADBEEF, 1'b0, 32'h0);
        checkOutput("be wr rvalid", {31'b0, d1Rvalid}, 32'h1);
        checkOutput("be wr rdata",  d1Rdata, 32'h0);
        checkOutput("be wr err",    {31'b0, d1Err}, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, BASE + 32'd8, 32'h0, 1'b0, 32'h0);
        checkOutput("be rd rvalid", {31'b0, d1Rvalid}, 32'h1);
        checkOutput("be rd rdata",  d1Rdata, 32'h00AD00EF);
        checkOutput("be rd err",    {31'b0, d1Err}, 32'h0);
        idle();
        checkOutput("idle d_rvalid", {31'b0, d1Rvalid}, 32'h0);
        checkOutput("idle d_rdata hold", d1Rdata, 32'h00AD00EF);

        // Store and fetch to the same word in one cycle.
        applyStimulus(1'b1, 1'b1, 4'hF, BASE + 32'd4, 32'hAAAAAAAA, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 4'b1100, BASE + 32'd4, 32'h11223344, 1'b1, BASE + 32'd4);
        checkOutput("coll i_rvalid", {31'b0, i1Rvalid}, 32'h1);
        checkOutput("coll i_rdata",  i1Rdata, 32'h1122AAAA);
        checkOutput("coll i_err",    {31'b0, i1Err}, 32'h0);
        checkOutput("coll d_rvalid", {31'b0, d1Rvalid}, 32'h1);
        applyStimulus(1'b1, 1'b0, 4'h0, BASE + 32'd4, 32'h0, 1'b1, BASE + 32'd8);
        checkOutput("coll rdback d", d1Rdata, 32'h1122AAAA);
        checkOutput("fetch word8",   i1Rdata, 32'h00AD00EF);
        applyStimulus(1'b1, 1'b0, 4'h0, BASE + 32'd8, 32'h0, 1'b1, BASE + 32'd8);
        checkOutput("rd/fetch d", d1Rdata, 32'h00AD00EF);
        checkOutput("rd/fetch i", i1Rdata, 32'h00AD00EF);

        // Out-of-range accesses, one past the top and one below the base.
        applyStimulus(1'b1, 1'b1, 4'hF, BASE, 32'h01234567, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 4'hF, BASE + DEPTH * 4, 32'hFFFFFFFF, 1'b1, BASE + DEPTH * 4);
        checkOutput("oor i_rvalid", {31'b0, i1Rvalid}, 32'h1);
        checkOutput("oor i_err",    {31'b0, i1Err}, 32'h1);
        checkOutput("oor i_rdata",  i1Rdata, NOP);
        checkOutput("oor d_rvalid", {31'b0, d1Rvalid}, 32'h1);
        checkOutput("oor d_err",    {31'b0, d1Err}, 32'h1);
        checkOutput("oor d_rdata",  d1Rdata, 32'h0);
        idle();
        checkOutput("oor i_rvalid drop", {31'b0, i1Rvalid}, 32'h0);
        checkOutput("oor i_err hold",    {31'b0, i1Err}, 32'h1);
        applyStimulus(1'b1, 1'b0, 4'h0, BASE + 32'd2, 32'h0, 1'b1, BASE - 32'd4);
        checkOutput("oor no alias",  d1Rdata, 32'h01234567);
        checkOutput("rd err clear",  {31'b0, d1Err}, 32'h0);
        checkOutput("below base err",{31'b0, i1Err}, 32'h1);
        checkOutput("below base nop", i1Rdata, NOP);

        // Write with no byte enables is acknowledged but changes nothing.
        applyStimulus(1'b1, 1'b1, 4'h0, BASE, 32'hFFFFFFFF, 1'b0, 32'h0);
        checkOutput("be0 rvalid", {31'b0, d1Rvalid}, 32'h1);
        checkOutput("be0 err",    {31'b0, d1Err}, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, BASE, 32'h0, 1'b0, 32'h0);
        checkOutput("be0 rdback", d1Rdata, 32'h01234567);

        // Last word in range.
        applyStimulus(1'b1, 1'b1, 4'hF, BASE + DEPTH * 4 - 32'd4, 32'h5A5A5A5A, 1'b0, 32'h0);
        checkOutput("top wr err", {31'b0, d1Err}, 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, BASE + DEPTH * 4 - 32'd4);
        checkOutput("top fetch",     i1Rdata, 32'h5A5A5A5A);
        checkOutput("top fetch err", {31'b0, i1Err}, 32'h0);

        // Fill words 8..15, then stream eight back-to-back reads.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b1, 4'hF, BASE + 32'(4 * (8 + k)), 32'hC0DE0000 + 32'(k),
                          1'b0, 32'h0);
            checkOutput("fill rvalid", {31'b0, d1Rvalid}, 32'h1);
        end
        idle();
        idle();
        for (int j = 0; j <= 10; j++) begin
            checkOutput("lat2 rvalid", {31'b0, d2Rvalid}, {31'b0, (j >= 2 && j <= 9)});
            if (j >= 2 && j <= 9) begin
                checkOutput("lat2 rdata", d2Rdata, 32'hC0DE0000 + 32'(j - 2));
            end
            checkOutput("lat1 rvalid", {31'b0, d1Rvalid}, {31'b0, (j >= 1 && j <= 8)});
            if (j < 8) begin
                applyStimulus(1'b1, 1'b0, 4'h0, BASE + 32'(4 * (8 + j)), 32'h0, 1'b0, 32'h0);
            end else begin
                idle();
            end
        end
        checkOutput("lat2 rdata hold", d2Rdata, 32'hC0DE0007);

        // Reset one cycle after a read is accepted; a write during reset is ignored.
        idle();
        applyStimulus(1'b1, 1'b0, 4'h0, BASE + 32'd32, 32'h0, 1'b0, 32'h0);
        checkOutput("pre-rst lat1 rdata", d1Rdata, 32'hC0DE0000);
        rstN = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'hF, BASE, 32'hBAD0BAD0, 1'b0, 32'h0);
        rstN = 1'b1;
        checkOutput("mid-rst lat2 rvalid", {31'b0, d2Rvalid}, 32'h0);
        checkOutput("mid-rst lat2 rdata",  d2Rdata, 32'h0);
        checkOutput("mid-rst lat2 i_rdata", i2Rdata, NOP);
        idle();
        checkOutput("mid-rst lat2 rvalid+1", {31'b0, d2Rvalid}, 32'h0);
        idle();
        checkOutput("mid-rst lat2 rvalid+2", {31'b0, d2Rvalid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, BASE, 32'h0, 1'b0, 32'h0);
        checkOutput("rst wr ignored lat1", d1Rdata, 32'h01234567);
        idle();
        checkOutput("rst wr ignored lat2", d2Rdata, 32'h01234567);
        checkOutput("lat2 rvalid resume",  {31'b0, d2Rvalid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/tcm_2p.md
# tcm_2p

Parametrised two-port tightly-coupled memory replacing the combinational testbench RAM. The data port serves the LSU; the instruction port serves fetch. Both ports use a req/gnt/rvalid handshake with registered, configurable read latency, per-byte write enables and out-of-range error responses. Same-cycle write/fetch collisions resolve write-first, byte by byte.

## Interface
- `DATA_W`, default 32: word width; multiple of 8.
- `DEPTH`, default 16384: number of words; power of two.
- `ADDR_W`, default 32: byte-address width on both ports.
- `BASE_ADDR`, default 32'h0: byte address of word 0.
- `RD_LAT`, default 1: response latency in cycles; legal values 1 or 2.
- `clk_i` in 1: single clock, rising edge.
- `rst_n_i` in 1: synchronous active-low reset.
- `d_req_i` in 1: data request.
- `d_we_i` in 1: 1 = write, 0 = read.
- `d_be_i` in DATA_W/8: byte enables for writes.
- `d_addr_i` in ADDR_W: byte address.
- `d_wdata_i` in DATA_W: write data.
- `d_gnt_o` out 1: request accepted this cycle.
- `d_rvalid_o` out 1: response pulse, for both reads and writes.
- `d_rdata_o` out DATA_W: read data.
- `d_err_o` out 1: error flag, qualified by `d_rvalid_o`.
- `i_req_i` in 1: fetch request.
- `i_addr_i` in ADDR_W: fetch byte address.
- `i_gnt_o` out 1: fetch accepted.
- `i_rvalid_o` out 1: fetch response pulse.
- `i_rdata_o` out DATA_W: instruction word.
- `i_err_o` out 1: fetch error, qualified by `i_rvalid_o`.

## Operation
- `gnt_o` = `req_i` while out of reset. Both ports are always accepted, so there is no arbitration.
- Word index = (addr − BASE_ADDR) >> log2(DATA_W/8). Low address bits are ignored.
- In range: BASE_ADDR ≤ addr < BASE_ADDR + DEPTH·DATA_W/8. Compute with unsigned ADDR_W+1-bit arithmetic so wrap-around cannot alias.
- Out-of-range access:
  - No memory update.
  - The response carries err=1 and rdata=0.
  - For an instruction out-of-range access, `i_rdata_o` = NOP (32'h00000013, zero-extended).
- Write: bytes with `be`=1 are updated at the accepting clock edge. The response carries rdata=0 and err=0.
- Write with `be`=0: accepted and acknowledged, with no update.
- Read: returns the word as it stood before any write in the same cycle on the same port. Only one request per port per cycle, so this case cannot occur within a port.
- Collision (data write and fetch to the same word in the same cycle): the fetch returns the new value for enabled bytes and the old value for the other bytes.
- Data read colliding with a fetch is harmless; both ports return the stored word.
- Response outputs:
  - `rdata_o`/`err_o` hold their last value between pulses.
  - `rvalid_o` is high exactly one cycle per accepted request.
- The memory array is not reset.

## Timing
- Reset values: `d_rvalid_o`, `i_rvalid_o`, `d_err_o`, `i_err_o` = 0; `d_rdata_o` = 0; `i_rdata_o` = NOP. Both `gnt_o` = 0 while `rst_n_i`=0.
- Request accepted at edge N → `rvalid_o` high during cycle N+RD_LAT (RD_LAT=1: the cycle immediately after acceptance).
- Back-to-back requests every cycle give one response per cycle, in order, with no bubbles.
- RD_LAT=2 adds an output register stage. The memory read still happens at acceptance, so later writes cannot alter an in-flight response.
- Reset asserted mid-operation: all in-flight responses are dropped, with no `rvalid` after reset. Writes at edges where `rst_n_i`=0 are ignored.

## Structure
- Shared package `tcm_pkg`:
  - NOP_INSN constant.
  - RD_LAT legality check function.
  - `tcm_resp_t` struct {valid, err, rdata}.
- Sub-module `tcm_resp_pipe`: an RD_LAT-deep response shift register with a hold-on-idle data register and synchronous reset. It is instantiated once per port.
- Top level contains:
  - the storage array,
  - the range/index decode per port,
  - the byte-merge collision-forwarding logic,
  - the two `tcm_resp_pipe` instances.

## Test plan
- Reset with both reqs high → no gnt and no rvalid. First cycle after release: `i_rdata_o`=32'h00000013, `d_rdata_o`=0.
- Write 32'hDEADBEEF with be=4'b0101 to BASE+8 (prior contents 0), then read BASE+8 → rdata=32'h00AD00EF one cycle after acceptance (RD_LAT=1), err=0.
- Same cycle: data write 32'h11223344 with be=4'b1100 to BASE+4 (old 32'hAAAAAAAA) and fetch BASE+4 → i_rdata=32'h1122AAAA.
- Fetch BASE+DEPTH·4 → i_err=1, i_rdata=32'h00000013. Data write to the same address → d_err=1 and the memory is unchanged on readback.
- RD_LAT=2: reads on 8 consecutive cycles → 8 consecutive rvalid pulses starting 2 cycles after the first acceptance, with data in order.
- Reset pulsed one cycle after a read is accepted, with RD_LAT=2 → no rvalid is observed for that read.
